alu_iter: RTL and testbench

ALU_ITER -- requirements
Module: alu_iter

---
 rtl/alu_iter.sv | 178 +++++++++++++++++
 tb/tb_alu_iter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter.sv
// Integer ALU with iterative shifter: add/sub, compares and logic ops finish in one edge.
// Shifts by S>0 take ceil(S/SHIFT_STEP) edges after acceptance; o_busy high meanwhile.
// While o_busy=1, i_start is ignored (no queueing); state updates on falling edge of i_clk_n.
module alu_iter #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic            i_clk_n,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_in_a,
  input  logic [XLEN-1:0] i_in_b,
  input  logic [2:0]      i_funct3,
  input  logic [6:0]      i_funct7,
  input  logic            i_alu_imm,
  input  logic            i_word,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_alu_out
);

  // Remaining-count width holds both the largest shift amount and SHIFT_STEP itself.
  localparam int LOG2 = $clog2(XLEN);
  localparam int RW   = LOG2 + 1;
  localparam logic [RW-1:0]   STEP = RW'(SHIFT_STEP);
  localparam logic [XLEN-1:0] LO32 = XLEN'(32'hFFFF_FFFF);

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shop_t;

  // Sign-extend the low 32 bits to the full datapath width.
  function automatic logic [XLEN-1:0] f_sext32(input logic [XLEN-1:0] x);
    logic signed [31:0] v;
    v = x[31:0];
    return XLEN'(v);
  endfunction

  state_t          r_state;
  shop_t           r_shop;
  logic            r_word;
  logic            r_busy;
  logic            r_valid;
  logic [XLEN-1:0] r_alu_out;
  logic [XLEN-1:0] r_work;
  logic [RW-1:0]   r_rem;

  logic            w_accept;
  logic            w_word;
  logic            w_is_shift;
  logic            w_multi;
  logic            w_sub;
  shop_t           w_shop;
  logic [RW-1:0]   w_shamt;
  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_a_sext;
  logic [XLEN-1:0] w_work_init;
  logic [XLEN-1:0] w_result;

  logic [RW-1:0]   w_step;
  logic [XLEN-1:0] w_work_nxt;
  logic            w_last;
  logic [XLEN-1:0] w_final;

  // Decode the incoming request and compute every single-cycle result.
  always_comb begin
    w_accept    = i_start && !r_busy && (r_state == ST_IDLE);
    w_is_shift  = (i_funct3 == F3_SLL) || (i_funct3 == F3_SR);
    w_word      = (XLEN == 64) && i_word &&
                  ((i_funct3 == F3_ADD) || w_is_shift);
    w_sub       = !i_alu_imm && (i_funct7 == 7'b0100000);
    w_shop      = (i_funct3 == F3_SLL) ? SH_LL :
                  (i_funct7[5] ? SH_RA : SH_RL);
    w_shamt     = w_word ? RW'(i_in_b[4:0]) : RW'(i_in_b[LOG2-1:0]);
    w_multi     = w_is_shift && (w_shamt != '0);
    w_sum       = w_sub ? (i_in_a - i_in_b) : (i_in_a + i_in_b);
    w_a_sext    = f_sext32(i_in_a);

    // Word-mode right shifts run on a 64-bit register pre-filled so that bit 31
    // receives zeros (logical) or copies of bit 31 (arithmetic).
    w_work_init = i_in_a;
    if (w_word) begin
      if (w_shop == SH_RL) begin
        w_work_init = i_in_a & LO32;
      end else if (w_shop == SH_RA) begin
        w_work_init = w_a_sext;
      end
    end

    w_result = '0;
    case (i_funct3)
      F3_ADD:  w_result = w_word ? f_sext32(w_sum) : w_sum;
      F3_SLL,
      F3_SR:   w_result = w_word ? w_a_sext : i_in_a;
      F3_SLT:  w_result = XLEN'($signed(i_in_a) < $signed(i_in_b));
      F3_SLTU: w_result = XLEN'(i_in_a < i_in_b);
      F3_XOR:  w_result = i_in_a ^ i_in_b;
      F3_OR:   w_result = i_in_a | i_in_b;
      F3_AND:  w_result = i_in_a & i_in_b;
      default: w_result = '0;
    endcase
  end

  // One shift step of at most SHIFT_STEP bits on the captured work register.
  always_comb begin
    w_step     = (r_rem < STEP) ? r_rem : STEP;
    w_last     = (r_rem <= STEP);
    w_work_nxt = r_work;
    case (r_shop)
      SH_LL:   w_work_nxt = r_work << w_step;
      SH_RL:   w_work_nxt = r_work >> w_step;
      SH_RA:   w_work_nxt = $signed(r_work) >>> w_step;
      default: w_work_nxt = r_work;
    endcase
    w_final = r_word ? f_sext32(w_work_nxt) : w_work_nxt;
  end

  // Control FSM: single-cycle ops retire at acceptance, shifts iterate in ST_SHIFT.
  always_ff @(negedge i_clk_n) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_shop    <= SH_LL;
      r_word    <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_alu_out <= '0;
      r_work    <= '0;
      r_rem     <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_multi) begin
              r_work  <= w_work_init;
              r_rem   <= w_shamt;
              r_shop  <= w_shop;
              r_word  <= w_word;
              r_busy  <= 1'b1;
              r_state <= ST_SHIFT;
            end else begin
              r_alu_out <= w_result;
              r_valid   <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          r_work <= w_work_nxt;
          r_rem  <= r_rem - w_step;
          if (w_last) begin
            r_alu_out <= w_final;
            r_valid   <= 1'b1;
            r_busy    <= 1'b0;
            r_rem     <= '0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_valid   = r_valid;
  assign o_alu_out = r_alu_out;

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter: a 32-bit instance and a 64-bit instance, both SHIFT_STEP=4.
// Inputs change 1 time unit after each falling edge; outputs are checked at the same point.
module tb_alu_iter;

  logic clk_n;

  logic        rst32, start32, imm32, word32;
  logic [31:0] a32, b32;
  logic [2:0]  f3_32;
  logic [6:0]  f7_32;
  logic        busy32, valid32;
  logic [31:0] out32;

  logic        rst64, start64, imm64, word64;
  logic [63:0] a64, b64;
  logic [2:0]  f3_64;
  logic [6:0]  f7_64;
  logic        busy64, valid64;
  logic [63:0] out64;

  int n_chk;
  int n_fail;

  alu_iter #(.XLEN(32), .SHIFT_STEP(4)) u32 (
    .i_clk_n(clk_n), .i_rst(rst32), .i_start(start32),
    .i_in_a(a32), .i_in_b(b32), .i_funct3(f3_32), .i_funct7(f7_32),
    .i_alu_imm(imm32), .i_word(word32),
    .o_busy(busy32), .o_valid(valid32), .o_alu_out(out32)
  );

  alu_iter #(.XLEN(64), .SHIFT_STEP(4)) u64 (
    .i_clk_n(clk_n), .i_rst(rst64), .i_start(start64),
    .i_in_a(a64), .i_in_b(b64), .i_funct3(f3_64), .i_funct7(f7_64),
    .i_alu_imm(imm64), .i_word(word64),
    .o_busy(busy64), .o_valid(valid64), .o_alu_out(out64)
  );

  initial clk_n = 1'b1;
  always #5 clk_n = ~clk_n;

  task automatic tick;
    @(negedge clk_n);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic op32(input logic st, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] f3, input logic [6:0] f7, input logic imm);
    start32 = st; a32 = a; b32 = b; f3_32 = f3; f7_32 = f7; imm32 = imm;
  endtask

  task automatic op64(input logic st, input logic [63:0] a, input logic [63:0] b,
                      input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                      input logic wd);
    start64 = st; a64 = a; b64 = b; f3_64 = f3; f7_64 = f7; imm64 = imm; word64 = wd;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst32 = 1'b1; rst64 = 1'b1; word32 = 1'b0;
    op32(1'b0, 32'd0, 32'd0, 3'b000, 7'h00, 1'b0);
    op64(1'b0, 64'd0, 64'd0, 3'b000, 7'h00, 1'b0, 1'b0);
    tick;
    tick;
    chk("rst_busy32", busy32, 0);
    chk("rst_valid32", valid32, 0);
    chk("rst_out32", out32, 0);
    chk("rst_busy64", busy64, 0);
    chk("rst_out64", out64, 0);
    rst32 = 1'b0; rst64 = 1'b0;

    // sub 5-7
    op32(1'b1, 32'd5, 32'd7, 3'b000, 7'b0100000, 1'b0);
    tick;
    chk("sub_valid", valid32, 1);
    chk("sub_out", out32, 64'h0000_0000_FFFF_FFFE);
    chk("sub_busy", busy32, 0);
    // addi with the same funct7 bits adds
    op32(1'b1, 32'd5, 32'd7, 3'b000, 7'b0100000, 1'b1);
    tick;
    chk("addi_out", out32, 32'h0000_000C);
    chk("addi_valid", valid32, 1);
    // back-to-back single-cycle ops
    op32(1'b1, 32'hFFFF_FFFF, 32'd2, 3'b000, 7'h00, 1'b0);
    tick;
    chk("add_wrap", out32, 32'h0000_0001);
    op32(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b010, 7'h00, 1'b0);
    tick;
    chk("slt", out32, 32'h0000_0001);
    op32(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b011, 7'h00, 1'b0);
    tick;
    chk("sltu", out32, 32'h0000_0000);
    op32(1'b1, 32'h0000_F0F0, 32'h0000_0FF0, 3'b100, 7'h00, 1'b0);
    tick;
    chk("xor", out32, 32'h0000_FF00);
    op32(1'b1, 32'h0000_F000, 32'h0000_000F, 3'b110, 7'h00, 1'b0);
    tick;
    chk("or", out32, 32'h0000_F00F);
    op32(1'b1, 32'h0000_FF00, 32'h0000_0FF0, 3'b111, 7'h00, 1'b0);
    tick;
    chk("and", out32, 32'h0000_0F00);
    chk("and_valid", valid32, 1);
    start32 = 1'b0;
    tick;
    chk("idle_novalid", valid32, 0);
    chk("idle_hold", out32, 32'h0000_0F00);

    // SRA by 31: busy for 8 edges, extra request ignored, operands changed mid-shift
    op32(1'b1, 32'h8000_0000, 32'd31, 3'b101, 7'b0100000, 1'b0);
    tick;
    chk("sra_accept_busy", busy32, 1);
    chk("sra_accept_novalid", valid32, 0);
    op32(1'b1, 32'd1, 32'd1, 3'b000, 7'h00, 1'b0);
    for (int i = 1; i < 8; i++) begin
      tick;
      chk("sra_busy", busy32, 1);
      chk("sra_novalid", valid32, 0);
    end
    tick;
    chk("sra_valid", valid32, 1);
    chk("sra_busy_clr", busy32, 0);
    chk("sra_out", out32, 32'hFFFF_FFFF);
    start32 = 1'b0;
    tick;
    chk("sra_no_queue", valid32, 0);
    chk("sra_hold", out32, 32'hFFFF_FFFF);

    // SLL amount 0 is single cycle
    op32(1'b1, 32'h0000_1234, 32'd0, 3'b001, 7'h00, 1'b0);
    tick;
    chk("sll0_valid", valid32, 1);
    chk("sll0_busy", busy32, 0);
    chk("sll0_out", out32, 32'h0000_1234);
    // SLL by 5 takes 2 edges
    op32(1'b1, 32'h0000_1234, 32'd5, 3'b001, 7'h00, 1'b0);
    tick;
    chk("sll5_busy0", busy32, 1);
    op32(1'b0, 32'hDEAD_BEEF, 32'd0, 3'b000, 7'h00, 1'b0);
    tick;
    chk("sll5_busy1", busy32, 1);
    chk("sll5_novalid", valid32, 0);
    tick;
    chk("sll5_valid", valid32, 1);
    chk("sll5_out", out32, 32'h0002_4680);
    // SRAI (immediate form still honours funct7[5]) and SRL
    op32(1'b1, 32'h8000_0000, 32'd4, 3'b101, 7'b0100000, 1'b1);
    tick;
    start32 = 1'b0;
    tick;
    chk("srai_out", out32, 32'hF800_0000);
    op32(1'b1, 32'h8000_0000, 32'd4, 3'b101, 7'h00, 1'b0);
    tick;
    start32 = 1'b0;
    tick;
    chk("srl_out", out32, 32'h0800_0000);

    // reset on the 3rd edge of a 31-bit shift, with a simultaneous request
    op32(1'b1, 32'd1, 32'd31, 3'b001, 7'h00, 1'b0);
    tick;
    start32 = 1'b0;
    tick;
    chk("abort_busy_pre", busy32, 1);
    rst32 = 1'b1;
    op32(1'b1, 32'd2, 32'd3, 3'b000, 7'h00, 1'b0);
    tick;
    chk("abort_novalid", valid32, 0);
    chk("abort_busy", busy32, 0);
    chk("abort_out", out32, 0);
    rst32 = 1'b0;
    tick;
    chk("post_rst_valid", valid32, 1);
    chk("post_rst_out", out32, 32'd5);
    start32 = 1'b0;

    // 64-bit word operations
    op64(1'b1, 64'h0000_0000_7FFF_FFFF, 64'd1, 3'b000, 7'h00, 1'b0, 1'b1);
    tick;
    chk("addw_valid", valid64, 1);
    chk("addw_out", out64, 64'hFFFF_FFFF_8000_0000);
    op64(1'b1, 64'h0000_0000_7FFF_FFFF, 64'd1, 3'b000, 7'h00, 1'b0, 1'b0);
    tick;
    chk("add64_out", out64, 64'h0000_0000_8000_0000);
    op64(1'b1, 64'hFFFF_FFFF_8000_0000, 64'd4, 3'b101, 7'h00, 1'b0, 1'b1);
    tick;
    chk("srlw_busy", busy64, 1);
    start64 = 1'b0;
    tick;
    chk("srlw_valid", valid64, 1);
    chk("srlw_out", out64, 64'h0000_0000_0800_0000);
    op64(1'b1, 64'hFFFF_FFFF_8000_0000, 64'd4, 3'b101, 7'b0100000, 1'b0, 1'b1);
    tick;
    start64 = 1'b0;
    tick;
    chk("sraw_out", out64, 64'hFFFF_FFFF_F800_0000);
    op64(1'b1, 64'h0000_0001_8000_0000, 64'd0, 3'b001, 7'h00, 1'b0, 1'b1);
    tick;
    chk("sllw0_out", out64, 64'hFFFF_FFFF_8000_0000);
    op64(1'b1, 64'h0000_0001_8000_0000, 64'd0, 3'b110, 7'h00, 1'b0, 1'b1);
    tick;
    chk("or_word_ignored", out64, 64'h0000_0001_8000_0000);
    op64(1'b1, 64'd1, 64'd40, 3'b001, 7'h00, 1'b0, 1'b0);
    tick;
    start64 = 1'b0;
    for (int i = 1; i < 10; i++) tick;
    chk("sll40_busy", busy64, 1);
    tick;
    chk("sll40_valid", valid64, 1);
    chk("sll40_out", out64, 64'h0000_0100_0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
